// File: rtl/pc_pkg.sv
// Shared constants for the program-counter generation unit.
// Select codes name which source feeds the next PC value.
package pc_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Next-PC source select codes
  localparam logic [2:0] SEL_SEQ     = 3'd0;
  localparam logic [2:0] SEL_HOLD    = 3'd1;
  localparam logic [2:0] SEL_BRANCH  = 3'd2;
  localparam logic [2:0] SEL_PENDING = 3'd3;
  localparam logic [2:0] SEL_TRAP    = 3'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority selector.
// Priority: trap (PC_TRAP_EN builds only), pending-redirect consume,
// branch, stall hold, sequential. Also flags the first branch seen during
// a stall so the top level can buffer its target.
// Optional feature macro: PC_TRAP_EN.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_addr_i,
  input  logic            pending_i,
  input  logic [XLEN-1:0] pending_tgt_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_add_i,
`ifdef PC_TRAP_EN
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_vector_i,
`endif
  output logic [2:0]      sel_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] branch_tgt_o,
  output logic            capture_o
);

  // Branch targets are halfword aligned, trap vectors word aligned
  localparam logic [XLEN-1:0] ALIGN2_MASK = {{(XLEN-1){1'b1}}, 1'b0};
`ifdef PC_TRAP_EN
  localparam logic [XLEN-1:0] ALIGN4_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`endif

  assign branch_tgt_o = branch_addr_i & ALIGN2_MASK;

  // Resolve the highest-priority next-PC source
  always_comb begin
    sel_o     = SEL_SEQ;
    capture_o = 1'b0;
`ifdef PC_TRAP_EN
    if (trap_req_i) begin
      sel_o = SEL_TRAP;
    end else
`endif
    if (pending_i && !stall_i) begin
      sel_o = SEL_PENDING;
    end else if (branch_taken_i && !stall_i) begin
      sel_o = SEL_BRANCH;
    end else if (stall_i) begin
      sel_o = SEL_HOLD;
      // Only the first branch of a stall is buffered; the frozen EX stage
      // keeps re-presenting it, so later ones are ignored while pending.
      if (branch_taken_i && !pending_i) begin
        capture_o = 1'b1;
      end else begin
        capture_o = 1'b0;
      end
    end else begin
      sel_o = SEL_SEQ;
    end
  end

  // Map the chosen source to the next PC value
  always_comb begin
    next_pc_o = pc_add_i;
    case (sel_o)
      SEL_SEQ:     next_pc_o = pc_add_i;
      SEL_HOLD:    next_pc_o = pc_i;
      SEL_BRANCH:  next_pc_o = branch_tgt_o;
      SEL_PENDING: next_pc_o = pending_tgt_i;
`ifdef PC_TRAP_EN
      SEL_TRAP:    next_pc_o = trap_vector_i & ALIGN4_MASK;
`endif
      default:     next_pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter generation unit for the fetch stage.
// Owns the PC, the buffered-redirect register and the Flush pulse.
// A branch resolved during a stall is latched and applied once the stall
// releases, so no redirect is lost to a stall/branch collision.
// Optional feature macro: PC_TRAP_EN (trap request/vector redirect).
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Do_Stall,
  input  logic            Is_Branch_Taken,
  input  logic [XLEN-1:0] Branch_Address,
`ifdef PC_TRAP_EN
  input  logic            Trap_Req,
  input  logic [XLEN-1:0] Trap_Vector,
`endif
  output logic [XLEN-1:0] Pc_Out,
  output logic [XLEN-1:0] Pc_Add_Out,
  output logic            Flush,
  output logic            Redirect_Pending
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pending_tgt_q;
  logic [XLEN-1:0] pending_tgt_d;
  logic            pending_q;
  logic            pending_d;
  logic            flush_q;
  logic            flush_d;

  logic [2:0]      sel_s;
  logic [XLEN-1:0] next_pc_s;
  logic [XLEN-1:0] branch_tgt_s;
  logic            capture_s;
  logic [XLEN-1:0] pc_add_s;

  // Sequential increment wraps naturally modulo 2^XLEN
  assign pc_add_s = pc_q + XLEN'(INSTR_BYTES);

  pc_next_sel #(
    .XLEN (XLEN)
  ) u_sel (
    .stall_i        (Do_Stall),
    .branch_taken_i (Is_Branch_Taken),
    .branch_addr_i  (Branch_Address),
    .pending_i      (pending_q),
    .pending_tgt_i  (pending_tgt_q),
    .pc_i           (pc_q),
    .pc_add_i       (pc_add_s),
`ifdef PC_TRAP_EN
    .trap_req_i     (Trap_Req),
    .trap_vector_i  (Trap_Vector),
`endif
    .sel_o          (sel_s),
    .next_pc_o      (next_pc_s),
    .branch_tgt_o   (branch_tgt_s),
    .capture_o      (capture_s)
  );

  // Next state of the pending-redirect buffer and the flush pulse
  always_comb begin
    pending_d     = pending_q;
    pending_tgt_d = pending_tgt_q;
    flush_d       = 1'b0;
    case (sel_s)
      SEL_TRAP,
      SEL_PENDING: begin
        pending_d = 1'b0;
        flush_d   = 1'b1;
      end
      SEL_BRANCH: begin
        flush_d = 1'b1;
      end
      SEL_HOLD: begin
        if (capture_s) begin
          pending_d     = 1'b1;
          pending_tgt_d = branch_tgt_s;
        end else begin
          pending_d     = pending_q;
          pending_tgt_d = pending_tgt_q;
        end
      end
      SEL_SEQ: begin
        flush_d = 1'b0;
      end
      default: begin
        flush_d = 1'b0;
      end
    endcase
  end

  // PC, pending buffer and flush registers; reset discards any pending redirect
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q          <= RESET_VECTOR;
      pending_q     <= 1'b0;
      pending_tgt_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      pc_q          <= next_pc_s;
      pending_q     <= pending_d;
      pending_tgt_q <= pending_tgt_d;
      flush_q       <= flush_d;
    end
  end

  assign Pc_Out           = pc_q;
  assign Pc_Add_Out       = pc_add_s;
  assign Flush            = flush_q;
  assign Redirect_Pending = pending_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit (XLEN=32, step 4, reset 0).
// Trap scenario compiled only when PC_TRAP_EN is defined.
module tb_pc_next_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Do_Stall;
  logic        Is_Branch_Taken;
  logic [31:0] Branch_Address;
  logic [31:0] Pc_Out;
  logic [31:0] Pc_Add_Out;
  logic        Flush;
  logic        Redirect_Pending;
`ifdef PC_TRAP_EN
  logic        Trap_Req;
  logic [31:0] Trap_Vector;
`endif

  int checks = 0;
  int passes = 0;

  pc_next_unit #(
    .XLEN         (32),
    .INSTR_BYTES  (4),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Do_Stall         (Do_Stall),
    .Is_Branch_Taken  (Is_Branch_Taken),
    .Branch_Address   (Branch_Address),
`ifdef PC_TRAP_EN
    .Trap_Req         (Trap_Req),
    .Trap_Vector      (Trap_Vector),
`endif
    .Pc_Out           (Pc_Out),
    .Pc_Add_Out       (Pc_Add_Out),
    .Flush            (Flush),
    .Redirect_Pending (Redirect_Pending)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Do_Stall = 1'b0; Is_Branch_Taken = 1'b0; Branch_Address = 32'h0;
`ifdef PC_TRAP_EN
    Trap_Req = 1'b0; Trap_Vector = 32'h0;
`endif
    tick(); tick();
    checks++; if (Pc_Out !== 32'h0) $display("FAIL reset_pc got %h want %h", Pc_Out, 32'h0); else passes++;
    checks++; if (Flush !== 1'b0) $display("FAIL reset_flush got %b want 0", Flush); else passes++;
    checks++; if (Redirect_Pending !== 1'b0) $display("FAIL reset_pending got %b want 0", Redirect_Pending); else passes++;
    checks++; if (Pc_Add_Out !== 32'h4) $display("FAIL reset_add got %h want %h", Pc_Add_Out, 32'h4); else passes++;
    Rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = 32'(i * 4);
      checks++; if (Pc_Out !== exp) $display("FAIL seq_pc[%0d] got %h want %h", i, Pc_Out, exp); else passes++;
      checks++; if (Pc_Add_Out !== exp + 32'h4) $display("FAIL seq_add[%0d] got %h want %h", i, Pc_Add_Out, exp + 32'h4); else passes++;
      checks++; if (Flush !== 1'b0) $display("FAIL seq_flush[%0d] got %b want 0", i, Flush); else passes++;
      tick();
    end
  endtask

  task automatic test_branch();
    checks++; if (Pc_Out !== 32'h10) $display("FAIL br_start got %h want %h", Pc_Out, 32'h10); else passes++;
    Is_Branch_Taken = 1'b1; Branch_Address = 32'h101;
    tick();
    Is_Branch_Taken = 1'b0;
    checks++; if (Pc_Out !== 32'h100) $display("FAIL br_pc got %h want %h", Pc_Out, 32'h100); else passes++;
    checks++; if (Flush !== 1'b1) $display("FAIL br_flush got %b want 1", Flush); else passes++;
    tick();
    checks++; if (Pc_Out !== 32'h104) $display("FAIL br_after got %h want %h", Pc_Out, 32'h104); else passes++;
    checks++; if (Flush !== 1'b0) $display("FAIL br_flush_drop got %b want 0", Flush); else passes++;
  endtask

  task automatic test_stall_branch();
    Is_Branch_Taken = 1'b1; Branch_Address = 32'h20;
    tick();
    Is_Branch_Taken = 1'b0; Do_Stall = 1'b1;
    tick();
    checks++; if (Pc_Out !== 32'h20) $display("FAIL stall_hold got %h want %h", Pc_Out, 32'h20); else passes++;
    checks++; if (Redirect_Pending !== 1'b0) $display("FAIL stall_nopend got %b want 0", Redirect_Pending); else passes++;
    Is_Branch_Taken = 1'b1; Branch_Address = 32'h200;
    tick();
    checks++; if (Pc_Out !== 32'h20) $display("FAIL sb_hold1 got %h want %h", Pc_Out, 32'h20); else passes++;
    checks++; if (Redirect_Pending !== 1'b1) $display("FAIL sb_pend1 got %b want 1", Redirect_Pending); else passes++;
    checks++; if (Flush !== 1'b0) $display("FAIL sb_flush1 got %b want 0", Flush); else passes++;
    Branch_Address = 32'h300;
    tick(); tick();
    checks++; if (Pc_Out !== 32'h20) $display("FAIL sb_hold3 got %h want %h", Pc_Out, 32'h20); else passes++;
    checks++; if (Redirect_Pending !== 1'b1) $display("FAIL sb_pend3 got %b want 1", Redirect_Pending); else passes++;
    Do_Stall = 1'b0;
    tick();
    Is_Branch_Taken = 1'b0;
    checks++; if (Pc_Out !== 32'h200) $display("FAIL sb_consume got %h want %h", Pc_Out, 32'h200); else passes++;
    checks++; if (Flush !== 1'b1) $display("FAIL sb_flush got %b want 1", Flush); else passes++;
    checks++; if (Redirect_Pending !== 1'b0) $display("FAIL sb_clear got %b want 0", Redirect_Pending); else passes++;
    tick();
    checks++; if (Pc_Out !== 32'h204) $display("FAIL sb_after got %h want %h", Pc_Out, 32'h204); else passes++;
    checks++; if (Flush !== 1'b0) $display("FAIL sb_flush_drop got %b want 0", Flush); else passes++;
  endtask

  task automatic test_wrap();
    Is_Branch_Taken = 1'b1; Branch_Address = 32'hFFFF_FFFC;
    tick();
    Is_Branch_Taken = 1'b0;
    checks++; if (Pc_Out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want %h", Pc_Out, 32'hFFFF_FFFC); else passes++;
    checks++; if (Pc_Add_Out !== 32'h0) $display("FAIL wrap_add got %h want %h", Pc_Add_Out, 32'h0); else passes++;
    tick();
    checks++; if (Pc_Out !== 32'h0) $display("FAIL wrap_next got %h want %h", Pc_Out, 32'h0); else passes++;
  endtask

  task automatic test_reset_pending();
    Do_Stall = 1'b1; Is_Branch_Taken = 1'b1; Branch_Address = 32'h400;
    tick();
    checks++; if (Redirect_Pending !== 1'b1) $display("FAIL rp_set got %b want 1", Redirect_Pending); else passes++;
    Rst = 1'b1;
    tick();
    checks++; if (Pc_Out !== 32'h0) $display("FAIL rp_pc got %h want %h", Pc_Out, 32'h0); else passes++;
    checks++; if (Redirect_Pending !== 1'b0) $display("FAIL rp_pend got %b want 0", Redirect_Pending); else passes++;
    checks++; if (Flush !== 1'b0) $display("FAIL rp_flush got %b want 0", Flush); else passes++;
    Rst = 1'b0; Do_Stall = 1'b0; Is_Branch_Taken = 1'b0;
    tick();
    checks++; if (Pc_Out !== 32'h4) $display("FAIL rp_nojump got %h want %h", Pc_Out, 32'h4); else passes++;
    checks++; if (Flush !== 1'b0) $display("FAIL rp_noflush got %b want 0", Flush); else passes++;
  endtask

  task automatic test_back_to_back();
    Is_Branch_Taken = 1'b1; Branch_Address = 32'h500;
    tick();
    checks++; if (Pc_Out !== 32'h500) $display("FAIL b2b_pc1 got %h want %h", Pc_Out, 32'h500); else passes++;
    checks++; if (Flush !== 1'b1) $display("FAIL b2b_flush1 got %b want 1", Flush); else passes++;
    Branch_Address = 32'h603;
    tick();
    Is_Branch_Taken = 1'b0;
    checks++; if (Pc_Out !== 32'h602) $display("FAIL b2b_pc2 got %h want %h", Pc_Out, 32'h602); else passes++;
    checks++; if (Flush !== 1'b1) $display("FAIL b2b_flush2 got %b want 1", Flush); else passes++;
    tick();
    checks++; if (Pc_Out !== 32'h606) $display("FAIL b2b_pc3 got %h want %h", Pc_Out, 32'h606); else passes++;
    checks++; if (Flush !== 1'b0) $display("FAIL b2b_flush3 got %b want 0", Flush); else passes++;
  endtask

`ifdef PC_TRAP_EN
  task automatic test_trap();
    Do_Stall = 1'b1; Is_Branch_Taken = 1'b1; Branch_Address = 32'h400;
    tick();
    checks++; if (Redirect_Pending !== 1'b1) $display("FAIL trap_setup got %b want 1", Redirect_Pending); else passes++;
    Trap_Req = 1'b1; Trap_Vector = 32'h8000_0003;
    tick();
    Trap_Req = 1'b0; Do_Stall = 1'b0; Is_Branch_Taken = 1'b0;
    checks++; if (Pc_Out !== 32'h8000_0000) $display("FAIL trap_pc got %h want %h", Pc_Out, 32'h8000_0000); else passes++;
    checks++; if (Flush !== 1'b1) $display("FAIL trap_flush got %b want 1", Flush); else passes++;
    checks++; if (Redirect_Pending !== 1'b0) $display("FAIL trap_pend got %b want 0", Redirect_Pending); else passes++;
    tick();
    checks++; if (Pc_Out !== 32'h8000_0004) $display("FAIL trap_after got %h want %h", Pc_Out, 32'h8000_0004); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_branch();
    test_wrap();
    test_reset_pending();
    test_back_to_back();
`ifdef PC_TRAP_EN
    test_trap();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Program-counter generation unit for the fetch stage. It owns the PC register and selects the next PC from sequential increment, hold (stall), branch redirect, or a buffered redirect. It fixes the stall-plus-branch collision by latching the target until the stall releases. It is parametrised in address width, increment size and reset vector, and sits between the EX-stage branch resolution and the instruction-memory address port.

Parameters:
XLEN, 32, PC/address width in bits
INSTR_BYTES, 4, sequential increment; 2 allowed for compressed fetch
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous active-high reset
Do_Stall  input  1  hazard unit freeze request; hold PC
Is_Branch_Taken  input  1  EX stage resolved taken branch/jump
Branch_Address  input  XLEN  redirect target (ALU output)
Pc_Out  output  XLEN  registered current PC, to IMEM and IF/ID
Pc_Add_Out  output  XLEN  combinational Pc_Out + INSTR_BYTES
Flush  output  1  registered 1-cycle pulse: a redirect was loaded last edge, squash IF/ID
Redirect_Pending  output  1  registered; buffered redirect target is waiting
Trap_Req  input  1  (PC_TRAP_EN only) trap/exception redirect request
Trap_Vector  input  XLEN  (PC_TRAP_EN only) trap handler address

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Rst); all state updates on the rising edge of Clk.
- Reset: Pc_Out=RESET_VECTOR, Flush=0, Redirect_Pending=0, pending target register=0. Rst wins over every other input.
- Next-PC priority, highest first: trap (if compiled in), pending-redirect consume, branch, stall hold, sequential.
- Sequential: if no other case applies, Pc_Out <= Pc_Add_Out. Flush=0.
- Stall only (Do_Stall=1, Is_Branch_Taken=0): Pc_Out holds. Flush=0.
- Branch, no stall, nothing pending: Pc_Out <= {Branch_Address[XLEN-1:1],1'b0} (bit0 cleared). Flush=1 next cycle.
- Branch during stall: Pc_Out holds. Target latched (bit0 cleared) into the pending register. Redirect_Pending=1 from the next cycle.
  - Only the first capture counts; further branches while pending and still stalled are ignored. The frozen EX stage re-presents the same branch.
- Pending consume: on the first cycle with Redirect_Pending=1 and Do_Stall=0, Pc_Out <= pending target, Redirect_Pending<=0, Flush=1 next cycle.
  - A coincident Is_Branch_Taken is ignored, because pending is older.
- Latency: redirect is visible on Pc_Out exactly 1 cycle after the accepting edge. No bubble beyond the Flush cycle.
- Arithmetic: Pc_Add_Out wraps modulo 2^XLEN. For example, XLEN=32, Pc_Out=32'hFFFF_FFFC gives Pc_Add_Out=32'h0000_0000.
- Flush is asserted for exactly one cycle per loaded redirect, including back-to-back redirects.
- Reset mid-stall with a pending redirect: the pending redirect is discarded and the PC goes to RESET_VECTOR.

Optional Feature:
PC_TRAP_EN
- Defined:
  - Trap_Req/Trap_Vector ports exist. Trap_Req=1 has highest non-reset priority and overrides Do_Stall.
  - On a trap: Pc_Out <= {Trap_Vector[XLEN-1:2],2'b00}, the pending redirect is cleared, and Flush=1 next cycle.
- Undefined: the ports are absent and the trap path is not synthesised. Behaviour is otherwise identical.

Decomposition:
- Package pc_pkg holds:
  - XLEN_DEFAULT, RESET_VECTOR_DEFAULT.
  - The select encoding constants SEL_SEQ, SEL_HOLD, SEL_BRANCH, SEL_PENDING, SEL_TRAP (3-bit).
- One sub-module, pc_next_sel: the combinational priority selector producing the select code and next-PC value.
  - The top level keeps the PC, pending, and Flush registers.

Test Plan:
- Reset, then 4 free-running cycles -> Pc_Out 0,4,8,C; Flush=0 throughout; Pc_Add_Out=Pc_Out+4.
- Pc_Out=0x10, Is_Branch_Taken=1, Branch_Address=0x101, no stall -> next Pc_Out=0x100, Flush=1 one cycle, then 0x104.
- Pc_Out=0x20, Do_Stall=1 for 3 cycles with Is_Branch_Taken=1, target 0x200 in cycle 1 and 0x300 in cycle 2 -> Pc_Out holds 0x20, Redirect_Pending=1. Stall drops -> Pc_Out=0x200, Flush=1, pending cleared.
- Pc_Out=0xFFFF_FFFC, no events, XLEN=32 -> next Pc_Out=0x0000_0000.
- Pending set (target 0x400), assert Rst -> Pc_Out=RESET_VECTOR, Redirect_Pending=0, Flush=0; no later jump to 0x400.
- PC_TRAP_EN: Do_Stall=1, Trap_Req=1, Trap_Vector=0x8000_0003, pending 0x400 -> Pc_Out=0x8000_0000, Flush=1, Redirect_Pending=0.
